// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : main control FSM for the multicycle MIPS datapath.
// Rev 1.0
// ============================================================================
module multicycle_control #(
   parameter int unsigned FETCH_WAIT_MAX = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OP,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ZeroExt,
   output logic [3:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] State,
   output logic       Error
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_RTEXEC   = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_IEXEC    = 4'd10,
      S_IWB      = 4'd11,
      S_JUMP     = 4'd12,
      S_JR       = 4'd13,
      S_ERROR    = 4'd14
   } state_t;

   localparam logic [5:0] C_OP_RTYPE = 6'b000000;
   localparam logic [5:0] C_OP_J     = 6'b000010;
   localparam logic [5:0] C_OP_JAL   = 6'b000011;
   localparam logic [5:0] C_OP_BEQ   = 6'b000100;
   localparam logic [5:0] C_OP_BNE   = 6'b000101;
   localparam logic [5:0] C_OP_ADDI  = 6'b001000;
   localparam logic [5:0] C_OP_ANDI  = 6'b001100;
   localparam logic [5:0] C_OP_ORI   = 6'b001101;
   localparam logic [5:0] C_OP_LUI   = 6'b001111;
   localparam logic [5:0] C_OP_LW    = 6'b100011;
   localparam logic [5:0] C_OP_SW    = 6'b101011;
   localparam logic [5:0] C_FN_JR    = 6'b001000;

   localparam logic [3:0] C_ALU_ADD  = 4'b0000;
   localparam logic [3:0] C_ALU_SUB  = 4'b0001;
   localparam logic [3:0] C_ALU_OR   = 4'b0010;
   localparam logic [3:0] C_ALU_AND  = 4'b0011;
   localparam logic [3:0] C_ALU_LUI  = 4'b0100;
   localparam logic [3:0] C_ALU_RT   = 4'b0111;

   localparam int CW = (FETCH_WAIT_MAX < 2) ? 1 : $clog2(FETCH_WAIT_MAX + 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q;
   logic            timeout;

   // Wait counter only runs while a memory access is stalled; any other state clears it.
   always_comb begin
      cnt_d   = '0;
      timeout = 1'b0;
      if ((state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE) && !MemReady) begin
         cnt_d = cnt_q + CW'(1);
         if (FETCH_WAIT_MAX != 0 && (32'(cnt_q) + 32'd1) >= FETCH_WAIT_MAX) begin
            timeout = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     state_d = S_FETCH;
         S_FETCH: begin
            if (timeout)       state_d = S_ERROR;
            else if (MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (OP)
               C_OP_LW, C_OP_SW:                        state_d = S_MEMADR;
               C_OP_RTYPE:                              state_d = (Funct == C_FN_JR) ? S_JR : S_RTEXEC;
               C_OP_BEQ, C_OP_BNE:                      state_d = S_BRANCH;
               C_OP_ADDI, C_OP_ANDI, C_OP_ORI, C_OP_LUI: state_d = S_IEXEC;
               C_OP_J, C_OP_JAL:                        state_d = S_JUMP;
               default:                                 state_d = S_ERROR;
            endcase
         end
         S_MEMADR:   state_d = (OP == C_OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (timeout)       state_d = S_ERROR;
            else if (MemReady) state_d = S_MEMWB;
         end
         S_MEMWRITE: begin
            if (timeout)       state_d = S_ERROR;
            else if (MemReady) state_d = S_FETCH;
         end
         S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_JR: state_d = S_FETCH;
         S_RTEXEC:   state_d = S_ALUWB;
         S_IEXEC:    state_d = S_IWB;
         S_ERROR:    state_d = S_ERROR;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_q | (state_d == S_ERROR);
      end
   end

   // Outputs depend only on the state plus MemReady/Zero/OP, so reset drops every strobe at once.
   always_comb begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 2'b00;
      MemtoReg = 2'b00;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ZeroExt  = 1'b0;
      ALUOp    = C_ALU_ADD;
      PCSource = 2'b00;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_DECODE:   ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMREAD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b01;
         end
         S_MEMWRITE: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_RTEXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = C_ALU_RT;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUOp    = C_ALU_SUB;
            PCSource = 2'b01;
            PCWrite  = ((OP == C_OP_BEQ) && Zero) || ((OP == C_OP_BNE) && !Zero);
         end
         S_IEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ZeroExt = (OP != C_OP_ADDI);
            case (OP)
               C_OP_ANDI: ALUOp = C_ALU_AND;
               C_OP_ORI:  ALUOp = C_ALU_OR;
               C_OP_LUI:  ALUOp = C_ALU_LUI;
               default:   ALUOp = C_ALU_ADD;
            endcase
         end
         S_IWB:      RegWrite = 1'b1;
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            if (OP == C_OP_JAL) begin
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               MemtoReg = 2'b10;
            end
         end
         S_JR: begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
         end
         default: ;
      endcase
   end

   assign State = state_q;
   assign Error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : directed self-checking bench for multicycle_control.
// Rev 1.0
// ============================================================================
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] OP = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b1;

   logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ZeroExt, Error;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
   logic [3:0] ALUOp, State;

   logic       u_PCWrite, u_IorD, u_MemRead, u_MemWrite, u_IRWrite, u_RegWrite, u_ALUSrcA, u_ZeroExt, u_Error;
   logic [1:0] u_RegDst, u_MemtoReg, u_ALUSrcB, u_PCSource;
   logic [3:0] u_ALUOp, u_State;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control #(.FETCH_WAIT_MAX(4)) dut (
      .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ZeroExt(ZeroExt), .ALUOp(ALUOp), .PCSource(PCSource), .State(State), .Error(Error)
   );

   multicycle_control dut_u (
      .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(u_PCWrite), .IorD(u_IorD), .MemRead(u_MemRead), .MemWrite(u_MemWrite), .IRWrite(u_IRWrite),
      .RegWrite(u_RegWrite), .RegDst(u_RegDst), .MemtoReg(u_MemtoReg), .ALUSrcA(u_ALUSrcA), .ALUSrcB(u_ALUSrcB),
      .ZeroExt(u_ZeroExt), .ALUOp(u_ALUOp), .PCSource(u_PCSource), .State(u_State), .Error(u_Error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (State !== 4'd0 || Error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state cyc %0d: State=%0d Error=%b, required 0/0", i, State, Error);
         end
         checks++;
         if ({PCWrite, MemRead, MemWrite, IRWrite, RegWrite} !== 5'b0 ||
             {IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource} !== 16'b0) begin
            errors++;
            $display("FAIL reset_outputs cyc %0d: strobes=%b selects=%b, required all 0", i,
                     {PCWrite, MemRead, MemWrite, IRWrite, RegWrite},
                     {IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource});
         end
      end
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (State !== 4'd0) begin
         errors++;
         $display("FAIL reset_release: State=%0d, required 0", State);
      end
      tick();
      checks++;
      if (State !== 4'd1 || MemRead !== 1'b1 || IorD !== 1'b0 || ALUSrcB !== 2'b01) begin
         errors++;
         $display("FAIL first_fetch: State=%0d MemRead=%b IorD=%b ALUSrcB=%b, required 1/1/0/01",
                  State, MemRead, IorD, ALUSrcB);
      end
   endtask

   task automatic test_add();
      logic [3:0] exp_s [5] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
      apply_reset();
      OP = 6'b000000; Funct = 6'b100000; MemReady = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (State !== exp_s[i]) begin
            errors++;
            $display("FAIL add_state step %0d: State=%0d, required %0d", i, State, exp_s[i]);
         end
         checks++;
         if (RegWrite !== (i == 3) || (i == 3 && RegDst !== 2'b01)) begin
            errors++;
            $display("FAIL add_regwrite step %0d: RegWrite=%b RegDst=%b", i, RegWrite, RegDst);
         end
         if (i == 0) begin
            checks++;
            if (PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
               errors++;
               $display("FAIL add_fetch_load: PCWrite=%b IRWrite=%b, required 1/1", PCWrite, IRWrite);
            end
         end
         if (i == 2) begin
            checks++;
            if (ALUOp !== 4'b0111 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
               errors++;
               $display("FAIL add_rtexec: ALUOp=%b ALUSrcA=%b ALUSrcB=%b, required 0111/1/00",
                        ALUOp, ALUSrcA, ALUSrcB);
            end
         end
         if (i < 4) tick();
      end
   endtask

   task automatic test_mid_reset();
      OP = 6'b000000; Funct = 6'b100000; MemReady = 1'b1;
      repeat (3) tick();
      checks++;
      if (State !== 4'd8 || RegWrite !== 1'b1) begin
         errors++;
         $display("FAIL midreset_setup: State=%0d RegWrite=%b, required 8/1", State, RegWrite);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (State !== 4'd0 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin
         errors++;
         $display("FAIL midreset_abort: State=%0d RegWrite=%b PCWrite=%b, required 0/0/0",
                  State, RegWrite, PCWrite);
      end
      #1;
      reset = 1'b1;
   endtask

   task automatic test_lw_stall();
      logic [3:0] exp_s [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
      logic       mr    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      apply_reset();
      OP = 6'b100011; Funct = 6'd0; MemReady = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         MemReady = mr[i];
         #1;
         checks++;
         if (State !== exp_s[i]) begin
            errors++;
            $display("FAIL lw_state step %0d: State=%0d, required %0d", i, State, exp_s[i]);
         end
         if (i >= 3 && i <= 5) begin
            checks++;
            if (IorD !== 1'b1 || MemRead !== 1'b1 || MemWrite !== 1'b0) begin
               errors++;
               $display("FAIL lw_memread step %0d: IorD=%b MemRead=%b MemWrite=%b, required 1/1/0",
                        i, IorD, MemRead, MemWrite);
            end
         end
         if (i == 6) begin
            checks++;
            if (RegWrite !== 1'b1 || MemtoReg !== 2'b01 || RegDst !== 2'b00) begin
               errors++;
               $display("FAIL lw_memwb: RegWrite=%b MemtoReg=%b RegDst=%b, required 1/01/00",
                        RegWrite, MemtoReg, RegDst);
            end
         end
         if (i < 7) tick();
      end
      checks++;
      if (Error !== 1'b0) begin
         errors++;
         $display("FAIL lw_no_timeout: Error=%b, required 0", Error);
      end
   endtask

   task automatic test_sw_imm();
      // sw: FETCH DECODE MEMADR MEMWRITE FETCH
      OP = 6'b101011; MemReady = 1'b1;
      repeat (3) tick();
      checks++;
      if (State !== 4'd6 || MemWrite !== 1'b1 || MemRead !== 1'b0 || IorD !== 1'b1) begin
         errors++;
         $display("FAIL sw_memwrite: State=%0d MemWrite=%b MemRead=%b IorD=%b, required 6/1/0/1",
                  State, MemWrite, MemRead, IorD);
      end
      tick();
      OP = 6'b001101;
      repeat (2) tick();
      checks++;
      if (State !== 4'd10 || ZeroExt !== 1'b1 || ALUOp !== 4'b0010 || ALUSrcB !== 2'b10) begin
         errors++;
         $display("FAIL ori_iexec: State=%0d ZeroExt=%b ALUOp=%b ALUSrcB=%b, required 10/1/0010/10",
                  State, ZeroExt, ALUOp, ALUSrcB);
      end
      tick();
      checks++;
      if (State !== 4'd11 || RegWrite !== 1'b1 || RegDst !== 2'b00 || MemtoReg !== 2'b00) begin
         errors++;
         $display("FAIL ori_iwb: State=%0d RegWrite=%b RegDst=%b MemtoReg=%b, required 11/1/00/00",
                  State, RegWrite, RegDst, MemtoReg);
      end
      tick();
      OP = 6'b001000;
      repeat (2) tick();
      checks++;
      if (State !== 4'd10 || ZeroExt !== 1'b0 || ALUOp !== 4'b0000) begin
         errors++;
         $display("FAIL addi_iexec: State=%0d ZeroExt=%b ALUOp=%b, required 10/0/0000", State, ZeroExt, ALUOp);
      end
      repeat (2) tick();
   endtask

   task automatic test_branch();
      logic [5:0] ops [3] = '{6'b000100, 6'b000101, 6'b000101};
      logic       zs  [3] = '{1'b1, 1'b1, 1'b0};
      logic       pcw [3] = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         OP = ops[k]; Zero = zs[k];
         repeat (2) tick();
         checks++;
         if (State !== 4'd9 || PCWrite !== pcw[k] || PCSource !== 2'b01 || ALUOp !== 4'b0001) begin
            errors++;
            $display("FAIL branch case %0d: State=%0d PCWrite=%b PCSource=%b ALUOp=%b, required 9/%b/01/0001",
                     k, State, PCWrite, PCSource, ALUOp, pcw[k]);
         end
         tick();
         checks++;
         if (State !== 4'd1) begin
            errors++;
            $display("FAIL branch_return case %0d: State=%0d, required 1", k, State);
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_jump();
      logic [5:0] ops [3] = '{6'b000011, 6'b000010, 6'b000000};
      logic [3:0] st  [3] = '{4'd12, 4'd12, 4'd13};
      logic       rw  [3] = '{1'b1, 1'b0, 1'b0};
      logic [1:0] src [3] = '{2'b10, 2'b10, 2'b11};
      for (int k = 0; k < 3; k++) begin
         OP = ops[k]; Funct = 6'b001000;
         repeat (2) tick();
         checks++;
         if (State !== st[k] || PCWrite !== 1'b1 || RegWrite !== rw[k] || PCSource !== src[k]) begin
            errors++;
            $display("FAIL jump case %0d: State=%0d PCWrite=%b RegWrite=%b PCSource=%b, required %0d/1/%b/%b",
                     k, State, PCWrite, RegWrite, PCSource, st[k], rw[k], src[k]);
         end
         if (k == 0) begin
            checks++;
            if (RegDst !== 2'b10 || MemtoReg !== 2'b10) begin
               errors++;
               $display("FAIL jal_link: RegDst=%b MemtoReg=%b, required 10/10", RegDst, MemtoReg);
            end
         end
         tick();
      end
      Funct = 6'd0;
   endtask

   task automatic test_illegal();
      OP = 6'b111111;
      repeat (2) tick();
      checks++;
      if (State !== 4'd14 || Error !== 1'b1) begin
         errors++;
         $display("FAIL illegal_error: State=%0d Error=%b, required 14/1", State, Error);
      end
      repeat (2) tick();
      checks++;
      if (State !== 4'd14 || Error !== 1'b1 ||
          {PCWrite, MemRead, MemWrite, IRWrite, RegWrite} !== 5'b0) begin
         errors++;
         $display("FAIL illegal_sticky: State=%0d Error=%b strobes=%b, required 14/1/00000",
                  State, Error, {PCWrite, MemRead, MemWrite, IRWrite, RegWrite});
      end
      apply_reset();
      checks++;
      if (State !== 4'd0 || Error !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clear: State=%0d Error=%b, required 0/0", State, Error);
      end
   endtask

   task automatic test_timeout();
      OP = 6'b000000; Funct = 6'b100000;
      apply_reset();
      MemReady = 1'b0;
      tick();
      repeat (3) tick();
      checks++;
      if (State !== 4'd1 || Error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: State=%0d Error=%b after 3 stalls, required 1/0", State, Error);
      end
      tick();
      checks++;
      if (State !== 4'd14 || Error !== 1'b1 || MemRead !== 1'b0) begin
         errors++;
         $display("FAIL timeout_expire: State=%0d Error=%b MemRead=%b, required 14/1/0", State, Error, MemRead);
      end
      checks++;
      if (u_State !== 4'd1 || u_Error !== 1'b0) begin
         errors++;
         $display("FAIL unbounded_wait: State=%0d Error=%b, required 1/0", u_State, u_Error);
      end
      MemReady = 1'b1;
      apply_reset();
      checks++;
      if (State !== 4'd0 || Error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: State=%0d Error=%b, required 0/0", State, Error);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mid_reset();
      test_lw_stall();
      test_sw_imm();
      test_branch();
      test_jump();
      test_illegal();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
